icache_resp: RTL
================

Name: icache_resp

Overview:
- Instruction-side responder for the pipeline fetch stage.
- Takes the fetch PC every cycle and returns `instr`/`instr_valid` combinationally on a hit.
- Small direct-mapped, flop-based instruction cache with 64-bit lines (two instructions per line).
- On a miss, runs a valid/ready refill against a 64-bit backing memory port. Fetch holds its PC while `instr_valid`=0.

Parameters:
- NSETS, 16, number of lines; power of two, ≥2; IDX=log2(NSETS).
- RST_MISS_CNT, 0, reset value of the miss counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- pc  in  64  fetch address from the fetch stage; bits [1:0] are ignored (RV64, no compressed instructions).
- instr  out  32  fetched instruction; 32'h13 when `instr_valid`=0.
- instr_valid  out  1  `instr` corresponds to the current `pc`.
- flush  in  1  fence.i: invalidate all lines.
- mem_req_valid  out  1  refill request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  64  refill address, 8-byte aligned.
- mem_resp_valid  in  1  refill data valid.
- mem_resp_data  in  64  refill line; [31:0] is word 0, [63:32] is word 1.
- miss_cnt  out  32  number of misses taken, saturating.

Behaviour:
- Address split:
  - offset = pc[2:0], word select = pc[2].
  - index = pc[IDX+2:3].
  - tag = pc[63:IDX+3].
- Storage: per line one valid bit, one tag and 64 data bits, all in flops. Data needs no reset; valid bits do.
- Reset (`rst`=1 at an edge), at the next edge:
  - all valid bits = 0, state = IDLE, `drop` = 0, `miss_cnt` = RST_MISS_CNT.
  - `mem_req_valid` = 0, `mem_req_addr` = 0, `instr_valid` = 0, `instr` = 32'h13.
  - Reset mid-refill abandons the refill. Any later `mem_resp_valid` is ignored until a new request is issued.
- hit = valid[index] && tag match.
- Combinational outputs:
  - `instr_valid` = (state==IDLE) && hit && !`flush`.
  - `instr` = selected word when `instr_valid`, else 32'h13.
- FSM states: IDLE, REQ, RESP.
  - IDLE, with miss (`!hit && !flush`): latch `mem_req_addr` = {pc[63:3], 3'b0}, `miss_cnt`++ (saturate at 32'hFFFF_FFFF), go to REQ.
  - IDLE, with `flush`: clear all valid bits, stay in IDLE. No miss is taken that cycle.
  - REQ: `mem_req_valid`=1. `mem_req_addr` stays stable until `mem_req_valid`&&`mem_req_ready`, then go to RESP.
  - RESP: wait for `mem_resp_valid`. On it:
    - if `!drop`, write data/tag/valid at the index of the latched address;
    - clear `drop`;
    - go to IDLE.
- `mem_req_valid` = (state==REQ). No new request until the previous response has been consumed (one outstanding request).
- `mem_resp_valid` outside RESP is ignored.
- A `pc` change during REQ/RESP (jump) does not alter the in-flight refill. After returning to IDLE, the new `pc` is looked up normally.
- `flush` during REQ or RESP:
  - clears all valid bits immediately;
  - sets `drop`, so the pending response is consumed but not written.
  - `flush` in the same cycle as the `mem_resp_valid` it refers to also drops the write.
- Latency:
  - hit: 0 cycles (same cycle as `pc`).
  - minimum miss (ready and response each arriving on the first possible cycle): miss seen at cycle N, REQ at N+1, RESP at N+2, hit at N+3.
- Conflicting lines (same index, different tag) replace each other. Last fill wins.

Test Plan:
- Cold miss, `pc`=0x8000_0000, ready=1, response 64'h0000_0093_0010_0513 at the first RESP cycle:
  - `mem_req_valid`=1 with addr 0x8000_0000 at N+1;
  - `instr_valid`=1, `instr`=0x0010_0513 at N+3;
  - `miss_cnt`=1;
  - then `pc`=0x8000_0004 hits at once with `instr`=0x0000_0093, and `miss_cnt` stays 1.
- Backpressure: `mem_req_ready`=0 for 5 cycles → `mem_req_valid`=1 and addr 0x8000_0008 constant for all 5 cycles. Accepted on cycle 6; `instr_valid`=0 throughout.
- Conflict with NSETS=16:
  - fill 0x8000_0000, then access 0x8000_0080 → miss, same index 0;
  - then 0x8000_0000 → miss again;
  - `miss_cnt` increments 3 times in total.
- `flush` during RESP:
  - the response is consumed but no line is written;
  - a re-access to the same `pc` misses again with a new request;
  - a previously cached line at another index also misses.
- Jump during a miss: `pc` changes 0x8000_0000→0x8000_0100 in REQ → refill still targets 0x8000_0000. After IDLE, 0x8000_0100 takes its own miss; afterwards both lines hit.
- `rst` pulse during RESP → next cycle all lines miss, `mem_req_valid`=0, `miss_cnt`=0. A stray `mem_resp_valid` afterwards writes nothing.

Source files
------------

// File: rtl/icache_resp_if.sv
// Fetch-side and refill-side signals of the instruction cache responder.
// slave is the cache's view; master is the fetch stage / memory side.
interface icache_resp_if;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport slave (
    input  pc, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output instr, instr_valid, mem_req_valid, mem_req_addr
  );

  modport master (
    output pc, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instr, instr_valid, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_resp.sv
// Direct-mapped, flop-based instruction cache with 64-bit lines and a
// single-outstanding valid/ready refill port.
module icache_resp #(
  parameter int unsigned NSETS        = 16,
  parameter logic [31:0] RST_MISS_CNT = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  icache_resp_if.slave       bus,
  output logic [31:0]        miss_cnt
);
  localparam int unsigned IDX = $clog2(NSETS);
  localparam int unsigned TW  = 64 - IDX - 3;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q;
  logic [NSETS-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [NSETS];
  logic [63:0]       data_q [NSETS];
  logic              drop_q;
  logic              req_valid_q;
  logic [63:0]       addr_q;
  logic [31:0]       miss_cnt_q;

  logic [IDX-1:0]    idx;
  logic [IDX-1:0]    fill_idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic              fill_en;
  logic [63:0]       line;
  logic              unused_pc;

  assign idx       = bus.pc[IDX+2:3];
  assign tag       = bus.pc[63:IDX+3];
  assign fill_idx  = addr_q[IDX+2:3];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign line      = data_q[idx];
  assign unused_pc = ^bus.pc[1:0];

  assign bus.instr_valid   = (state_q == StIdle) && hit && !bus.flush;
  assign bus.instr         = bus.instr_valid ? (bus.pc[2] ? line[63:32] : line[31:0])
                                             : 32'h0000_0013;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = addr_q;
  assign miss_cnt          = miss_cnt_q;

  // A flush in the response cycle kills the write just like an earlier one.
  assign fill_en = !rst && (state_q == StResp) && bus.mem_resp_valid && !drop_q && !bus.flush;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_idx] <= bus.mem_resp_data;
      tag_q[fill_idx]  <= addr_q[63:IDX+3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      miss_cnt_q  <= RST_MISS_CNT;
    end else begin
      if (bus.flush) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (!bus.flush && !hit) begin
            addr_q      <= {bus.pc[63:3], 3'b000};
            miss_cnt_q  <= (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
            req_valid_q <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (bus.flush) drop_q <= 1'b1;
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.mem_resp_valid) begin
            if (fill_en) valid_q[fill_idx] <= 1'b1;
            drop_q  <= 1'b0;
            state_q <= StIdle;
          end else if (bus.flush) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
